layer_fwd_sequencer: RTL and testbench
======================================

Name: layer_fwd_sequencer

Overview:
Sequences one forward-pass layer through the unified buffer (UB), the 2x2 systolic array and the VPU.
- Accepts a layer command from the host/top-level controller.
- Issues, in order and with fixed spacing, the UB weight-read, input-read, bias-read and VPU write-back-address commands, and drives the VPU pathway select.
- Counts VPU result beats on both output columns to detect completion; a watchdog catches stalls.
- Sits between the host command interface and the UB read/write-address ports of the tpu top.

Parameters:
ADDR_W, 6, UB address/loc width
W_LAT, 4, idle cycles between weight-read start and input-read start (weight preload time)
BIAS_DLY, 2, idle cycles between input-read start and bias-read/write-address start
TIMEOUT, 64, max consecutive DRAIN cycles with no VPU valid before abort

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmd_valid_in  in  1  command present
cmd_ready_out  out  1  high only in IDLE
cmd_x_addr_in  in  ADDR_W  UB start address of inputs X
cmd_w_addr_in  in  ADDR_W  UB start address of weights
cmd_b_addr_in  in  ADDR_W  UB start address of biases
cmd_out_addr_in  in  ADDR_W  UB write-back start address
cmd_rows_in  in  ADDR_W  batch rows N (0..63)
cmd_w_transpose_in  in  1  read weights transposed
cmd_pathway_in  in  4  VPU data_pathway for this layer
ub_rd_weight_start_out  out  1  1-cycle pulse
ub_rd_weight_addr_out  out  ADDR_W  weight read address
ub_rd_weight_loc_out  out  ADDR_W  weight read row count (constant 2)
ub_rd_weight_transpose_out  out  1  weight transpose flag
ub_rd_input_start_out  out  1  1-cycle pulse
ub_rd_input_addr_out  out  ADDR_W  input read address
ub_rd_input_loc_out  out  ADDR_W  input read row count (N)
ub_rd_bias_start_out  out  1  1-cycle pulse
ub_rd_bias_addr_out  out  ADDR_W  bias read address
ub_rd_bias_loc_out  out  ADDR_W  bias read row count (N)
ub_wr_addr_valid_out  out  1  1-cycle pulse; latches write-back address in UB
ub_wr_addr_out  out  ADDR_W  write-back address
vpu_data_pathway_out  out  4  VPU routing select
vpu_valid_in_1  in  1  VPU column-1 result valid
vpu_valid_in_2  in  1  VPU column-2 result valid
busy_out  out  1  state != IDLE
done_out  out  1  1-cycle pulse on successful completion
err_out  out  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (checked at clock edge, any state including mid-command):
  - state=IDLE; all pulses, addr/loc outputs, transpose, pathway, busy, done, err = 0; cmd_ready_out=1 the cycle after reset deasserts.
  - The in-flight command is dropped; no further UB commands are issued.
- Accept: cmd_valid_in & cmd_ready_out at edge T registers all cmd fields and clears counters cnt1, cnt2 and the watchdog. The fields are held on addr/loc/transpose/pathway outputs until return to IDLE, then the outputs return to 0.
- Zero-row command (N=0): state DONE at T+1, done_out=1 at T+1, no UB pulses; IDLE at T+2.
- FSM for N>0: IDLE -> LOAD_W -> WAIT_W -> FEED -> WAIT_B -> BIAS -> DRAIN -> DONE -> IDLE.
  - LOAD_W (cycle T+1): ub_rd_weight_start_out=1.
  - WAIT_W: lasts exactly W_LAT cycles.
  - FEED (1 cycle): ub_rd_input_start_out=1.
  - WAIT_B: lasts exactly BIAS_DLY cycles.
  - BIAS (1 cycle): ub_rd_bias_start_out=1 and ub_wr_addr_valid_out=1 together.
  - DRAIN: waits until cnt1==N and cnt2==N.
  - DONE (1 cycle): done_out=1.
- Defaults: weight start at T+1, input start at T+6, bias/wr-addr at T+9, DRAIN from T+10.
- Counting:
  - cnt1/cnt2 increment on vpu_valid_in_1/vpu_valid_in_2 in FEED, WAIT_B, BIAS and DRAIN; valids in any other state are ignored.
  - Both columns may count in the same cycle. Each counter saturates at N.
  - The DRAIN->DONE check uses counter values including the current cycle's increment, so the final beat at cycle C gives done_out at C+1.
- Watchdog (DRAIN only): counter resets on any vpu valid, otherwise increments.
  - On reaching TIMEOUT: err_out=1 for 1 cycle, done_out stays 0, next state IDLE.
- cmd_valid_in while busy is ignored (no queueing). Exactly one done_out or one err_out per accepted command.

Test Plan:
- Basic: N=3, x=0x10, w=0x00, b=0x20, out=0x30, pathway=4'b1100 accepted at cycle 0; column valids 3 each from cycle 12 -> weight pulse @1 (addr 0x00, loc 2), input pulse @6 (0x10, loc 3), bias+wr_addr pulse @9 (0x20/0x30), done_out exactly 1 cycle after the 3rd beat of the later column; busy 1..done cycle.
- Simultaneous/skewed: N=2, col1 valids at 11,12 and col2 at 12,13 -> done_out at 14; extra col1 valid at 13 does not break saturation.
- Zero rows: N=0 -> done_out at cycle 1, no start/wr_addr pulses, cmd_ready_out high at cycle 2.
- Watchdog: N=2, only col1 valids -> err_out at DRAIN entry+64 (cycle 74 if last valid before DRAIN), done_out never asserted, IDLE next cycle.
- Reset mid-op: rst during WAIT_B -> no input/bias pulse afterwards, all outputs 0, new command accepted right after reset deasserts runs normally.
- Back-to-back: second cmd_valid_in held during first command -> ignored until IDLE, then accepted; weight pulse 1 cycle after acceptance.

Source files
------------

// File: rtl/layer_fwd_sequencer.sv
// Sequences one forward-pass layer: UB weight/input/bias reads, write-back address and VPU pathway select.
// Weight read issues 1 cycle after accept; a single command in flight, cmd_ready_out low until back in IDLE.
module layer_fwd_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int W_LAT    = 4,
  parameter int BIAS_DLY = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [ADDR_W-1:0] cmd_x_addr_in,
  input  logic [ADDR_W-1:0] cmd_w_addr_in,
  input  logic [ADDR_W-1:0] cmd_b_addr_in,
  input  logic [ADDR_W-1:0] cmd_out_addr_in,
  input  logic [ADDR_W-1:0] cmd_rows_in,
  input  logic              cmd_w_transpose_in,
  input  logic [3:0]        cmd_pathway_in,
  output logic              ub_rd_weight_start_out,
  output logic [ADDR_W-1:0] ub_rd_weight_addr_out,
  output logic [ADDR_W-1:0] ub_rd_weight_loc_out,
  output logic              ub_rd_weight_transpose_out,
  output logic              ub_rd_input_start_out,
  output logic [ADDR_W-1:0] ub_rd_input_addr_out,
  output logic [ADDR_W-1:0] ub_rd_input_loc_out,
  output logic              ub_rd_bias_start_out,
  output logic [ADDR_W-1:0] ub_rd_bias_addr_out,
  output logic [ADDR_W-1:0] ub_rd_bias_loc_out,
  output logic              ub_wr_addr_valid_out,
  output logic [ADDR_W-1:0] ub_wr_addr_out,
  output logic [3:0]        vpu_data_pathway_out,
  input  logic              vpu_valid_in_1,
  input  logic              vpu_valid_in_2,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_WAIT_W, S_FEED, S_WAIT_B, S_BIAS, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] w;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] o;
    logic [ADDR_W-1:0] rows;
    logic              transpose;
    logic [3:0]        pathway;
  } cmd_t;

  localparam int DLY_MAX = (W_LAT > BIAS_DLY) ? W_LAT : BIAS_DLY;
  localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [DLY_W-1:0] W_LAST = DLY_W'((W_LAT > 0) ? W_LAT - 1 : 0);
  localparam logic [DLY_W-1:0] B_LAST = DLY_W'((BIAS_DLY > 0) ? BIAS_DLY - 1 : 0);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [ADDR_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              counting;

  always_comb begin
    state_d                = state_q;
    cmd_d                  = cmd_q;
    dly_d                  = dly_q;
    cnt1_d                 = cnt1_q;
    cnt2_d                 = cnt2_q;
    wd_d                   = wd_q;
    ub_rd_weight_start_out = 1'b0;
    ub_rd_input_start_out  = 1'b0;
    ub_rd_bias_start_out   = 1'b0;
    ub_wr_addr_valid_out   = 1'b0;
    done_out               = 1'b0;
    err_out                = 1'b0;

    // Result beats can arrive as soon as inputs start streaming.
    counting = (state_q == S_FEED) || (state_q == S_WAIT_B) ||
               (state_q == S_BIAS) || (state_q == S_DRAIN);
    if (counting && vpu_valid_in_1 && (cnt1_q != cmd_q.rows)) cnt1_d = cnt1_q + ADDR_W'(1);
    if (counting && vpu_valid_in_2 && (cnt2_q != cmd_q.rows)) cnt2_d = cnt2_q + ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          cmd_d.x         = cmd_x_addr_in;
          cmd_d.w         = cmd_w_addr_in;
          cmd_d.b         = cmd_b_addr_in;
          cmd_d.o         = cmd_out_addr_in;
          cmd_d.rows      = cmd_rows_in;
          cmd_d.transpose = cmd_w_transpose_in;
          cmd_d.pathway   = cmd_pathway_in;
          cnt1_d          = '0;
          cnt2_d          = '0;
          wd_d            = '0;
          dly_d           = '0;
          state_d         = (cmd_rows_in == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        ub_rd_weight_start_out = 1'b1;
        dly_d                  = '0;
        state_d                = (W_LAT == 0) ? S_FEED : S_WAIT_W;
      end
      S_WAIT_W: begin
        if (dly_q == W_LAST) state_d = S_FEED;
        else                 dly_d   = dly_q + DLY_W'(1);
      end
      S_FEED: begin
        ub_rd_input_start_out = 1'b1;
        dly_d                 = '0;
        state_d               = (BIAS_DLY == 0) ? S_BIAS : S_WAIT_B;
      end
      S_WAIT_B: begin
        if (dly_q == B_LAST) state_d = S_BIAS;
        else                 dly_d   = dly_q + DLY_W'(1);
      end
      S_BIAS: begin
        ub_rd_bias_start_out = 1'b1;
        ub_wr_addr_valid_out = 1'b1;
        state_d              = S_DRAIN;
      end
      S_DRAIN: begin
        // Abort wins over a completing beat landing in the same cycle.
        if (wd_q == WD_MAX) begin
          err_out = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = (vpu_valid_in_1 || vpu_valid_in_2) ? '0 : wd_q + WD_W'(1);
          if ((cnt1_d == cmd_q.rows) && (cnt2_d == cmd_q.rows)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      dly_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dly_q   <= dly_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      wd_q    <= wd_d;
    end
  end

  assign busy_out      = (state_q != S_IDLE);
  assign cmd_ready_out = (state_q == S_IDLE);

  // Command fields are visible only while a layer is in flight.
  assign ub_rd_weight_addr_out      = busy_out ? cmd_q.w : '0;
  assign ub_rd_weight_loc_out       = busy_out ? ADDR_W'(2) : '0;
  assign ub_rd_weight_transpose_out = busy_out ? cmd_q.transpose : 1'b0;
  assign ub_rd_input_addr_out       = busy_out ? cmd_q.x : '0;
  assign ub_rd_input_loc_out        = busy_out ? cmd_q.rows : '0;
  assign ub_rd_bias_addr_out        = busy_out ? cmd_q.b : '0;
  assign ub_rd_bias_loc_out         = busy_out ? cmd_q.rows : '0;
  assign ub_wr_addr_out             = busy_out ? cmd_q.o : '0;
  assign vpu_data_pathway_out       = busy_out ? cmd_q.pathway : 4'b0000;

endmodule

// File: tb/tb_layer_fwd_sequencer.sv
// Randomized and directed bench for layer_fwd_sequencer against a schedule-level reference model.
module tb_layer_fwd_sequencer;

  localparam int AW = 6, W_LAT = 4, BIAS_DLY = 2, TIMEOUT = 64, MAXC = 120;
  localparam logic [7:0] C_RDY = 8'h80, C_BUSY = 8'h40, C_W = 8'h20, C_I = 8'h10,
                         C_B = 8'h0C, C_DONE = 8'h02, C_ERR = 8'h01;

  logic clk, rst, cmd_valid_in, cmd_ready_out, cmd_w_transpose_in;
  logic [AW-1:0] cmd_x_addr_in, cmd_w_addr_in, cmd_b_addr_in, cmd_out_addr_in, cmd_rows_in;
  logic [3:0] cmd_pathway_in, vpu_data_pathway_out;
  logic ub_rd_weight_start_out, ub_rd_weight_transpose_out, ub_rd_input_start_out;
  logic ub_rd_bias_start_out, ub_wr_addr_valid_out, vpu_valid_in_1, vpu_valid_in_2;
  logic busy_out, done_out, err_out;
  logic [AW-1:0] ub_rd_weight_addr_out, ub_rd_weight_loc_out, ub_rd_input_addr_out;
  logic [AW-1:0] ub_rd_input_loc_out, ub_rd_bias_addr_out, ub_rd_bias_loc_out, ub_wr_addr_out;

  layer_fwd_sequencer #(.ADDR_W(AW), .W_LAT(W_LAT), .BIAS_DLY(BIAS_DLY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_x_addr_in(cmd_x_addr_in), .cmd_w_addr_in(cmd_w_addr_in),
    .cmd_b_addr_in(cmd_b_addr_in), .cmd_out_addr_in(cmd_out_addr_in),
    .cmd_rows_in(cmd_rows_in), .cmd_w_transpose_in(cmd_w_transpose_in),
    .cmd_pathway_in(cmd_pathway_in),
    .ub_rd_weight_start_out(ub_rd_weight_start_out), .ub_rd_weight_addr_out(ub_rd_weight_addr_out),
    .ub_rd_weight_loc_out(ub_rd_weight_loc_out), .ub_rd_weight_transpose_out(ub_rd_weight_transpose_out),
    .ub_rd_input_start_out(ub_rd_input_start_out), .ub_rd_input_addr_out(ub_rd_input_addr_out),
    .ub_rd_input_loc_out(ub_rd_input_loc_out),
    .ub_rd_bias_start_out(ub_rd_bias_start_out), .ub_rd_bias_addr_out(ub_rd_bias_addr_out),
    .ub_rd_bias_loc_out(ub_rd_bias_loc_out),
    .ub_wr_addr_valid_out(ub_wr_addr_valid_out), .ub_wr_addr_out(ub_wr_addr_out),
    .vpu_data_pathway_out(vpu_data_pathway_out),
    .vpu_valid_in_1(vpu_valid_in_1), .vpu_valid_in_2(vpu_valid_in_2),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit sv1 [MAXC];
  bit sv2 [MAXC];
  logic [7:0] ectl [MAXC];
  int end_c;
  logic [AW-1:0] d_x, d_w, d_b, d_o, d_n, e_x, e_w, e_b, e_o, e_n;
  logic d_t, e_t;
  logic [3:0] d_p, e_p;
  logic [7:0] obs_c;
  logic [46:0] obs_f;

  // Expected per-cycle control trace: fixed pulse schedule, then column beat counting until both reach N.
  function automatic void build_model(input int n);
    int c1, c2, quiet, t_in, t_b;
    for (int c = 0; c < MAXC; c++) ectl[c] = C_RDY;
    end_c = -1;
    if (n == 0) begin
      ectl[1] = C_BUSY | C_DONE;
      end_c   = 1;
    end else begin
      t_in = 1 + W_LAT + 1;
      t_b  = t_in + BIAS_DLY + 1;
      c1 = 0; c2 = 0; quiet = 0;
      for (int c = 1; c < MAXC - 1 && end_c < 0; c++) begin
        ectl[c] = C_BUSY;
        if (c == 1)    ectl[c] = ectl[c] | C_W;
        if (c == t_in) ectl[c] = ectl[c] | C_I;
        if (c == t_b)  ectl[c] = ectl[c] | C_B;
        if (c > t_b && quiet == TIMEOUT) begin
          ectl[c] = ectl[c] | C_ERR;
          end_c   = c;
        end else if (c >= t_in) begin
          c1 = (c1 + int'(sv1[c]) > n) ? n : c1 + int'(sv1[c]);
          c2 = (c2 + int'(sv2[c]) > n) ? n : c2 + int'(sv2[c]);
          if (c > t_b) begin
            quiet = (sv1[c] || sv2[c]) ? 0 : quiet + 1;
            if (c1 == n && c2 == n) begin
              ectl[c+1] = C_BUSY | C_DONE;
              end_c     = c + 1;
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [46:0] exp_fields(input logic busy);
    if (busy) return {e_w, AW'(2), e_t, e_x, e_n, e_b, e_n, e_o, e_p};
    return '0;
  endfunction

  task automatic set_cmd(input int n, input int x, input int w, input int b, input int o,
                         input logic t, input logic [3:0] p);
    d_n = AW'(n); d_x = AW'(x); d_w = AW'(w); d_b = AW'(b); d_o = AW'(o); d_t = t; d_p = p;
    e_n = d_n; e_x = d_x; e_w = d_w; e_b = d_b; e_o = d_o; e_t = d_t; e_p = d_p;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin sv1[c] = 1'b0; sv2[c] = 1'b0; end
  endtask

  // Cycle i of a command: drive just after the rising edge, sample at the falling edge.
  task automatic cycle_io(input int i, input logic hold, input logic r);
    @(posedge clk); #1;
    rst                = r;
    cmd_valid_in       = (i == 0) || hold;
    cmd_x_addr_in      = d_x; cmd_w_addr_in = d_w; cmd_b_addr_in = d_b;
    cmd_out_addr_in    = d_o; cmd_rows_in = d_n;
    cmd_w_transpose_in = d_t; cmd_pathway_in = d_p;
    vpu_valid_in_1     = sv1[i];
    vpu_valid_in_2     = sv2[i];
    @(negedge clk);
    obs_c = {cmd_ready_out, busy_out, ub_rd_weight_start_out, ub_rd_input_start_out,
             ub_rd_bias_start_out, ub_wr_addr_valid_out, done_out, err_out};
    obs_f = {ub_rd_weight_addr_out, ub_rd_weight_loc_out, ub_rd_weight_transpose_out,
             ub_rd_input_addr_out, ub_rd_input_loc_out, ub_rd_bias_addr_out,
             ub_rd_bias_loc_out, ub_wr_addr_out, vpu_data_pathway_out};
  endtask

  task automatic test_reset();
    clear_stim();
    set_cmd(5, 1, 2, 3, 4, 1'b1, 4'hA);
    cycle_io(0, 1'b0, 1'b1);
    cycle_io(1, 1'b0, 1'b1);
    n_checks++;
    if (obs_c !== C_RDY) $display("FAIL reset_ctl got=%b want=%b", obs_c, C_RDY); else n_pass++;
    n_checks++;
    if (obs_f !== 47'd0) $display("FAIL reset_fields got=%h want=0", obs_f); else n_pass++;
    cycle_io(1, 1'b0, 1'b0);
    cycle_io(1, 1'b0, 1'b0);
    n_checks++;
    if (obs_c !== C_RDY) $display("FAIL reset_release got=%b want=%b", obs_c, C_RDY); else n_pass++;
  endtask

  task automatic test_basic();
    int done_at = -1;
    clear_stim();
    set_cmd(3, 'h10, 'h00, 'h20, 'h30, 1'b0, 4'b1100);
    for (int c = 12; c < 15; c++) begin sv1[c] = 1'b1; sv2[c] = 1'b1; end
    build_model(3);
    for (int i = 0; i <= end_c + 1; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      if (obs_c[1] && done_at < 0) done_at = i;
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL basic_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
      n_checks++;
      if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL basic_fields cyc=%0d got=%h want=%h", i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
    end
    n_checks++;
    if (done_at !== 15) $display("FAIL basic_done_cycle got=%0d want=15", done_at); else n_pass++;
  endtask

  task automatic test_skewed();
    int done_at = -1;
    clear_stim();
    set_cmd(2, 'h05, 'h3A, 'h11, 'h2F, 1'b1, 4'b0110);
    sv1[11] = 1'b1; sv1[12] = 1'b1; sv1[13] = 1'b1;
    sv2[12] = 1'b1; sv2[13] = 1'b1;
    build_model(2);
    for (int i = 0; i <= end_c + 1; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      if (obs_c[1] && done_at < 0) done_at = i;
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL skew_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
      n_checks++;
      if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL skew_fields cyc=%0d got=%h want=%h", i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
    end
    n_checks++;
    if (done_at !== 14) $display("FAIL skew_done_cycle got=%0d want=14", done_at); else n_pass++;
  endtask

  task automatic test_zero_rows();
    int done_at = -1;
    clear_stim();
    set_cmd(0, 'h01, 'h02, 'h03, 'h04, 1'b1, 4'b1111);
    sv1[1] = 1'b1; sv2[1] = 1'b1; sv1[2] = 1'b1;
    build_model(0);
    for (int i = 0; i <= end_c + 1; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      if (obs_c[1] && done_at < 0) done_at = i;
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL zero_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
      n_checks++;
      if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL zero_fields cyc=%0d got=%h want=%h", i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
    end
    n_checks++;
    if (done_at !== 1) $display("FAIL zero_done_cycle got=%0d want=1", done_at); else n_pass++;
  endtask

  task automatic test_watchdog();
    int done_at = -1;
    int err_at  = -1;
    clear_stim();
    set_cmd(2, 'h08, 'h18, 'h28, 'h38, 1'b0, 4'b0011);
    sv1[6] = 1'b1; sv1[7] = 1'b1;
    build_model(2);
    for (int i = 0; i <= end_c + 1; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      if (obs_c[1] && done_at < 0) done_at = i;
      if (obs_c[0] && err_at < 0) err_at = i;
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL wdog_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
    end
    n_checks++;
    if (err_at !== 74) $display("FAIL wdog_err_cycle got=%0d want=74", err_at); else n_pass++;
    n_checks++;
    if (done_at !== -1) $display("FAIL wdog_no_done got=%0d want=-1", done_at); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_stim();
    set_cmd(3, 'h21, 'h22, 'h23, 'h24, 1'b1, 4'b1001);
    build_model(3);
    for (int i = 0; i < 7; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL rstmid_pre cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
    end
    cycle_io(7, 1'b0, 1'b1);
    n_checks++;
    if (obs_c !== C_BUSY) $display("FAIL rstmid_waitb got=%b want=%b", obs_c, C_BUSY); else n_pass++;
    clear_stim();
    set_cmd(2, 'h0C, 'h0D, 'h0E, 'h0F, 1'b0, 4'b0101);
    for (int c = 10; c < 14; c++) begin sv1[c] = 1'b1; sv2[c] = (c > 10); end
    sv1[2] = 1'b1;
    build_model(2);
    for (int i = 0; i <= end_c + 1; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL rstmid_post_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
      n_checks++;
      if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL rstmid_post_fields cyc=%0d got=%h want=%h", i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int w_at = -1;
    clear_stim();
    set_cmd(1, 'h31, 'h32, 'h33, 'h34, 1'b1, 4'b0001);
    sv1[10] = 1'b1; sv2[10] = 1'b1;
    build_model(1);
    for (int i = 0; i <= end_c; i++) begin
      cycle_io(i, 1'b1, 1'b0);
      if (i == 2) begin
        d_n = 6'd2; d_x = 6'h01; d_w = 6'h02; d_b = 6'h03; d_o = 6'h04; d_t = 1'b0; d_p = 4'b1110;
      end
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL b2b_first_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
      n_checks++;
      if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL b2b_first_fields cyc=%0d got=%h want=%h", i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
    end
    set_cmd(2, 'h01, 'h02, 'h03, 'h04, 1'b0, 4'b1110);
    clear_stim();
    for (int c = 8; c < 12; c++) begin sv1[c] = 1'b1; sv2[c] = 1'b1; end
    build_model(2);
    for (int i = 0; i <= end_c + 1; i++) begin
      cycle_io(i, 1'b0, 1'b0);
      if (obs_c[5] && w_at < 0) w_at = i;
      n_checks++;
      if (obs_c !== ectl[i]) $display("FAIL b2b_second_ctl cyc=%0d got=%b want=%b", i, obs_c, ectl[i]); else n_pass++;
      n_checks++;
      if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL b2b_second_fields cyc=%0d got=%h want=%h", i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
    end
    n_checks++;
    if (w_at !== 1) $display("FAIL b2b_weight_cycle got=%0d want=1", w_at); else n_pass++;
  endtask

  task automatic test_random();
    int n;
    bit starve;
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(0, 6));
      starve = ($urandom_range(0, 4) == 0);
      set_cmd(n, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      clear_stim();
      for (int c = 1; c < 40; c++) begin
        sv1[c] = ($urandom_range(0, 2) == 0);
        sv2[c] = starve ? 1'b0 : ($urandom_range(0, 2) == 0);
      end
      build_model(n);
      for (int i = 0; i <= end_c + 1; i++) begin
        cycle_io(i, 1'b0, 1'b0);
        n_checks++;
        if (obs_c !== ectl[i]) $display("FAIL rand_ctl cmd=%0d cyc=%0d got=%b want=%b", k, i, obs_c, ectl[i]); else n_pass++;
        n_checks++;
        if (obs_f !== exp_fields(ectl[i][6])) $display("FAIL rand_fields cmd=%0d cyc=%0d got=%h want=%h", k, i, obs_f, exp_fields(ectl[i][6])); else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid_in = 1'b0;
    vpu_valid_in_1 = 1'b0;
    vpu_valid_in_2 = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 1'b0, 4'b0000);
    cmd_x_addr_in = '0; cmd_w_addr_in = '0; cmd_b_addr_in = '0; cmd_out_addr_in = '0;
    cmd_rows_in = '0; cmd_w_transpose_in = 1'b0; cmd_pathway_in = 4'b0000;
    test_reset();
    test_basic();
    test_skewed();
    test_zero_rows();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
